// File: rtl/vote_pkg.sv
// Shared constants and state encoding for the vote collector.
package vote_pkg;
    localparam int N_VOTERS  = 4;
    localparam int VERDICT_W = 3;
    localparam int ID_W      = 2;

    typedef enum logic [1:0] {
        IDLE,
        OPEN,
        EVAL,
        DONE
    } state_t;
endpackage

// File: rtl/vote_collector_if.sv
// Vote handshake bundle between a vote source and the collector.
interface vote_collector_if;
    import vote_pkg::*;

    logic            vote_valid;
    logic [ID_W-1:0] vote_id;
    logic            vote_val;
    logic            vote_ready;

    modport master (
        output vote_valid,
        output vote_id,
        output vote_val,
        input  vote_ready
    );

    modport slave (
        input  vote_valid,
        input  vote_id,
        input  vote_val,
        output vote_ready
    );
endinterface

// File: rtl/vote_timer.sv
// Loadable session up-counter; tc flags the last cycle before timeout.
module vote_timer #(
    parameter  int TIMEOUT = 200,
    localparam int CW      = $clog2(TIMEOUT + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic en,
    output logic tc
);
    logic [CW-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= '0;
        end else if (en) begin
            count <= count + CW'(1);
        end
    end

    assign tc = (count == CW'(TIMEOUT - 1));
endmodule

// File: rtl/vote_collector.sv
// Session sequencer: collects one vote per voter, presents the ballot, latches the verdict.
module vote_collector
    import vote_pkg::*;
#(
    parameter int TIMEOUT = 200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 open_req,
    input  logic                 close_req,
    vote_collector_if.slave      vif,
    output logic                 dup_err,
    output logic [N_VOTERS-1:0]  ballot,
    output logic                 ballot_valid,
    input  logic [VERDICT_W-1:0] verdict_in,
    output logic [VERDICT_W-1:0] verdict,
    output logic                 verdict_valid,
    output logic                 busy
);
    state_t              state;
    logic [N_VOTERS-1:0] voted;
    logic [N_VOTERS-1:0] id_hot;
    logic [N_VOTERS-1:0] voted_nxt;
    logic                in_range;
    logic                accept;
    logic                open_go;
    logic                close_now;
    logic                tc;
    logic                ready_q;

    assign vif.vote_ready = ready_q;

    always_comb begin
        in_range = (int'(vif.vote_id) < N_VOTERS);
        id_hot   = '0;
        if (in_range) begin
            id_hot[vif.vote_id] = 1'b1;
        end
    end

    assign accept    = (state == OPEN) && vif.vote_valid &&
                       in_range && ((voted & id_hot) == '0);
    assign voted_nxt = voted | (accept ? id_hot : '0);
    assign close_now = (&voted_nxt) || close_req || tc;
    assign open_go   = open_req && ((state == IDLE) || (state == DONE));

    vote_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .load (open_go),
        .en   (state == OPEN),
        .tc   (tc)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            ballot        <= '0;
            voted         <= '0;
            verdict       <= '0;
            verdict_valid <= 1'b0;
            ballot_valid  <= 1'b0;
            ready_q       <= 1'b0;
            dup_err       <= 1'b0;
            busy          <= 1'b0;
        end else begin
            dup_err <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (open_go) begin
                        state         <= OPEN;
                        ballot        <= '0;
                        voted         <= '0;
                        verdict_valid <= 1'b0;
                        ready_q       <= 1'b1;
                        busy          <= 1'b1;
                    end
                end
                OPEN: begin
                    if (accept) begin
                        ballot <= (ballot & ~id_hot) |
                                  (vif.vote_val ? id_hot : '0);
                    end else if (vif.vote_valid) begin
                        dup_err <= 1'b1;
                    end
                    voted <= voted_nxt;
                    if (close_now) begin
                        state        <= EVAL;
                        ready_q      <= 1'b0;
                        ballot_valid <= 1'b1;
                    end
                end
                EVAL: begin
                    state         <= DONE;
                    verdict       <= verdict_in;
                    ballot_valid  <= 1'b0;
                    verdict_valid <= 1'b1;
                    busy          <= 1'b0;
                end
            endcase
        end
    end
endmodule
